dmem_latency_responder: RTL and testbench

//   Responder side of the pipelined core's data-memory port. It replaces the single-cycle DataMemory

---
 rtl/dmem_latency_responder.sv | 160 ++++++++++++++++
 tb/tb_dmem_latency_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_latency_responder.sv
// Word-addressed data-memory responder with valid/ready request and response handshakes
// and a fixed, parameterised access latency. Optional macro: DMEM_MISALIGN_ERR_EN.
module dmem_latency_responder #(
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter int unsigned LATENCY     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        busy
`ifdef DMEM_MISALIGN_ERR_EN
    ,
    output logic        resp_err
`endif
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    logic [31:0]   mem [DEPTH_WORDS];

    state_t        state;
    logic [CW-1:0] count;
    logic [AW-1:0] lat_idx;
    logic [31:0]   lat_wdata;
    logic          lat_write;
    logic          lat_misalign;

    logic [AW-1:0] req_idx;
    logic          req_misalign;
    logic          accept;

    logic          acc_en;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_wdata;
    logic          acc_write;
    logic          acc_misalign;
    logic          mem_we;
    logic [31:0]   rd_value;

    logic          unused_addr;

    assign req_idx     = req_addr[AW+1:2];
    assign accept      = (state == ST_IDLE) && req_valid;
    assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

`ifdef DMEM_MISALIGN_ERR_EN
    assign req_misalign = (req_addr[1:0] != 2'b00);
`else
    assign req_misalign = 1'b0;
`endif

    // With LATENCY=1 the access happens on the accept edge itself, straight from the request bus.
    always_comb begin
        acc_en       = 1'b0;
        acc_idx      = lat_idx;
        acc_wdata    = lat_wdata;
        acc_write    = lat_write;
        acc_misalign = lat_misalign;
        if (LATENCY == 1) begin
            acc_en       = accept;
            acc_idx      = req_idx;
            acc_wdata    = req_wdata;
            acc_write    = req_write;
            acc_misalign = req_misalign;
        end else begin
            acc_en = (state == ST_WAIT) && (count == CW'(1));
        end
        mem_we   = reset && acc_en && acc_write && !acc_misalign;
        rd_value = (acc_write || acc_misalign) ? '0 : mem[acc_idx];
    end

    // Array has no reset: contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            count        <= '0;
            lat_idx      <= '0;
            lat_wdata    <= '0;
            lat_write    <= 1'b0;
            lat_misalign <= 1'b0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            busy         <= 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
            resp_err     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_idx      <= req_idx;
                        lat_wdata    <= req_wdata;
                        lat_write    <= req_write;
                        lat_misalign <= req_misalign;
                        count        <= CW'(LATENCY - 1);
                        req_ready    <= 1'b0;
                        busy         <= 1'b1;
                        if (LATENCY == 1) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= rd_value;
`ifdef DMEM_MISALIGN_ERR_EN
                            resp_err   <= acc_misalign;
`endif
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    count <= count - CW'(1);
                    if (acc_en) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= rd_value;
`ifdef DMEM_MISALIGN_ERR_EN
                        resp_err   <= acc_misalign;
`endif
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
                        resp_err   <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_latency_responder.sv
// Directed bench: a LATENCY=4 instance (full-size RAM) and a LATENCY=1 instance (16-word RAM).
module tb_dmem_latency_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        a_valid, a_req_ready, a_write, a_resp_valid, a_rready, a_busy;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_valid, b_req_ready, b_write, b_resp_valid, b_rready, b_busy;
    logic [31:0] b_addr, b_wdata, b_rdata;
`ifdef DMEM_MISALIGN_ERR_EN
    logic        a_err, b_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_latency_responder #(.DEPTH_WORDS(16384), .LATENCY(4)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(a_valid), .req_ready(a_req_ready), .req_write(a_write),
        .req_addr(a_addr), .req_wdata(a_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_rready), .resp_rdata(a_rdata),
        .busy(a_busy)
`ifdef DMEM_MISALIGN_ERR_EN
        , .resp_err(a_err)
`endif
    );

    dmem_latency_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .req_valid(b_valid), .req_ready(b_req_ready), .req_write(b_write),
        .req_addr(b_addr), .req_wdata(b_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_rready), .resp_rdata(b_rdata),
        .busy(b_busy)
`ifdef DMEM_MISALIGN_ERR_EN
        , .resp_err(b_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full LATENCY=4 transaction with resp_ready held high; request bus scrambled after accept.
    task automatic xa(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [31:0] exp);
        a_valid = 1'b1; a_write = wr; a_addr = addr; a_wdata = data; a_rready = 1'b1;
        chk({tag, ".req_ready"}, a_req_ready, 1);
        tick();
        a_valid = 1'b0; a_write = ~wr; a_addr = 32'hFFFF_FFFC; a_wdata = '1;
        for (int i = 1; i <= 3; i++) begin
            chk({tag, ".early_valid"}, a_resp_valid, 0);
            chk({tag, ".busy"}, a_busy, 1);
            tick();
        end
        chk({tag, ".resp_valid"}, a_resp_valid, 1);
        chk({tag, ".rdata"}, a_rdata, exp);
        tick();
        chk({tag, ".valid_drop"}, a_resp_valid, 0);
        chk({tag, ".ready_back"}, a_req_ready, 1);
        chk({tag, ".busy_drop"}, a_busy, 0);
    endtask

    task automatic xb(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [31:0] exp);
        b_valid = 1'b1; b_write = wr; b_addr = addr; b_wdata = data; b_rready = 1'b1;
        chk({tag, ".req_ready"}, b_req_ready, 1);
        tick();
        b_valid = 1'b0; b_addr = '0; b_wdata = '0;
        chk({tag, ".resp_valid"}, b_resp_valid, 1);
        chk({tag, ".busy"}, b_busy, 1);
        chk({tag, ".rdata"}, b_rdata, exp);
        tick();
        chk({tag, ".valid_drop"}, b_resp_valid, 0);
        chk({tag, ".ready_back"}, b_req_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        a_valid = 0; a_write = 0; a_addr = '0; a_wdata = '0; a_rready = 0;
        b_valid = 0; b_write = 0; b_addr = '0; b_wdata = '0; b_rready = 0;

        // 1. reset held 3 cycles, then released
        repeat (3) tick();
        chk("rst.a_req_ready", a_req_ready, 1);
        chk("rst.a_resp_valid", a_resp_valid, 0);
        reset = 1'b1;
        tick();
        chk("rel.a_req_ready", a_req_ready, 1);
        chk("rel.a_resp_valid", a_resp_valid, 0);
        chk("rel.a_rdata", a_rdata, 0);
        chk("rel.a_busy", a_busy, 0);
        chk("rel.b_req_ready", b_req_ready, 1);
        chk("rel.b_resp_valid", b_resp_valid, 0);
        chk("rel.b_busy", b_busy, 0);

        // 2. store then load same word
        xa("st100", 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0);
        xa("ld100", 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);

        // 3. response back-pressure; requests during WAIT/RESP ignored
        xa("st10", 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h0);
        a_valid = 1'b1; a_write = 1'b0; a_addr = 32'h0000_0010; a_rready = 1'b0;
        tick();
        a_write = 1'b1; a_wdata = 32'h1111_1111;
        for (int i = 1; i <= 3; i++) begin
            chk("bp.early_valid", a_resp_valid, 0);
            chk("bp.req_ready_low", a_req_ready, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk("bp.hold_valid", a_resp_valid, 1);
            chk("bp.hold_rdata", a_rdata, 32'hCAFE_F00D);
            tick();
        end
        chk("bp.still_valid", a_resp_valid, 1);
        a_rready = 1'b1; a_valid = 1'b0;
        tick();
        chk("bp.valid_drop", a_resp_valid, 0);
        chk("bp.req_ready", a_req_ready, 1);
        xa("ld10_again", 1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D);

        // 4. address wrap modulo DEPTH_WORDS
        xa("st4", 1'b1, 32'h0000_0004, 32'h1234_5678, 32'h0);
        xa("ld10004", 1'b0, 32'h0001_0004, 32'h0, 32'h1234_5678);

        // 5. reset mid-store discards the pending write
        xa("st200_pre", 1'b1, 32'h0000_0200, 32'h5A5A_0001, 32'h0);
        a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h0000_0200; a_wdata = 32'hAAAA_5555;
        tick();
        a_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("abort.resp_valid", a_resp_valid, 0);
        chk("abort.busy", a_busy, 0);
        chk("abort.req_ready", a_req_ready, 1);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("abort.no_resp", a_resp_valid, 0);
            tick();
        end
        xa("ld200", 1'b0, 32'h0000_0200, 32'h0, 32'h5A5A_0001);

        // LATENCY=1 instance: accept+1 response and wrap on a 16-word array
        xb("l1.st8", 1'b1, 32'h0000_0008, 32'h0BAD_CAFE, 32'h0);
        xb("l1.ld48", 1'b0, 32'h0000_0048, 32'h0, 32'h0BAD_CAFE);
        xb("l1.st3c", 1'b1, 32'h0000_003C, 32'h7777_0000, 32'h0);
        xb("l1.ld3c", 1'b0, 32'h0000_003C, 32'h0, 32'h7777_0000);

`ifdef DMEM_MISALIGN_ERR_EN
        // 6. misaligned store: timed normally, flagged, no write
        a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h0000_0102; a_wdata = 32'h5555_AAAA;
        a_rready = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk("mis.early_valid", a_resp_valid, 0);
            tick();
        end
        chk("mis.resp_valid", a_resp_valid, 1);
        chk("mis.resp_err", a_err, 1);
        chk("mis.rdata", a_rdata, 0);
        tick();
        chk("mis.err_clear", a_err, 0);
        xa("mis.ld100", 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);

        b_valid = 1'b1; b_write = 1'b1; b_addr = 32'h0000_000A; b_wdata = 32'h1357_9BDF;
        b_rready = 1'b1;
        tick();
        b_valid = 1'b0;
        chk("l1mis.resp_valid", b_resp_valid, 1);
        chk("l1mis.resp_err", b_err, 1);
        tick();
        chk("l1mis.err_clear", b_err, 0);
        xb("l1mis.ld8", 1'b0, 32'h0000_0008, 32'h0, 32'h0BAD_CAFE);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
